// File: rtl/crp16_alu_mul_seq.sv
// crp16_alu_mul_seq: 16x16 -> 32-bit unsigned multiply sequencer.
// It borrows the shared CRP16 ALU adder for one shift-and-add step per clock.
// While busy it owns the ALU and drives the add select code.
// Each RUN step shifts the 33-bit {carry, sum, multiplier} word right by one.
// After 16 steps {acc, lo} holds the full product.
module crp16_alu_mul_seq #(
    parameter logic [3:0] ALU_ADD_SEL = 4'b0000,
    parameter int         ITER        = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] prod_hi,
    output logic [15:0] prod_lo,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic [3:0]  alu_select,
    input  logic [15:0] alu_result,
    input  logic        alu_c
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] acc_r;
    logic [15:0] lo_r;
    logic [15:0] mcand_r;
    logic [3:0]  count_r;
    logic [15:0] prod_hi_r;
    logic [15:0] prod_lo_r;
    logic        busy_r;
    logic        done_r;
    logic        count_last_s;
    logic [15:0] acc_nxt_s;
    logic [15:0] lo_nxt_s;

    // The ALU is combinational, so its sum and carry for the current step are
    // already valid. The carry lands in acc[15] and is never lost.
    assign count_last_s = (count_r == 4'(ITER - 1));
    assign acc_nxt_s    = {alu_c, alu_result[15:1]};
    assign lo_nxt_s     = {alu_result[0], lo_r[15:1]};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic. RUN lasts exactly ITER cycles and DONE lasts one cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (count_last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // ALU drive. The operands are live only in RUN; otherwise they are held at
    // zero so the shared ALU inputs stay deterministic.
    always_comb begin
        alu_x      = 16'h0000;
        alu_y      = 16'h0000;
        alu_select = ALU_ADD_SEL;
        if (state_r == ST_RUN) begin
            alu_x = acc_r;
            alu_y = lo_r[0] ? mcand_r : 16'h0000;
        end else begin
            alu_x = 16'h0000;
            alu_y = 16'h0000;
        end
    end

    // Datapath and registered status.
    // On the final step the product is captured straight from the shifted
    // value, so it is valid in the same cycle that done is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r     <= 16'h0000;
            lo_r      <= 16'h0000;
            mcand_r   <= 16'h0000;
            count_r   <= 4'h0;
            prod_hi_r <= 16'h0000;
            prod_lo_r <= 16'h0000;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        mcand_r <= a;
                        lo_r    <= b;
                        acc_r   <= 16'h0000;
                        count_r <= 4'h0;
                    end
                end
                ST_RUN: begin
                    acc_r   <= acc_nxt_s;
                    lo_r    <= lo_nxt_s;
                    count_r <= count_r + 4'd1;
                    if (count_last_s) begin
                        prod_hi_r <= acc_nxt_s;
                        prod_lo_r <= lo_nxt_s;
                    end
                end
                ST_DONE: begin
                    count_r <= 4'h0;
                end
                default: begin
                    count_r <= 4'h0;
                end
            endcase
            busy_r <= (state_nxt_s != ST_IDLE);
            done_r <= (state_nxt_s == ST_DONE);
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign prod_hi = prod_hi_r;
    assign prod_lo = prod_lo_r;

endmodule

// File: tb/tb_crp16_alu_mul_seq.sv
// Testbench for crp16_alu_mul_seq.
// A combinational adder stands in for the CRP16 ALU. A transaction-level model
// tracks the busy countdown and computes the product and the expected
// per-step ALU operands with plain arithmetic.
module tb_crp16_alu_mul_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] prod_hi;
    logic [15:0] prod_lo;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [3:0]  alu_select;
    logic [15:0] alu_result;
    logic        alu_c;
    logic [16:0] alu_sum;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    // Model state: cycles of busy remaining, the captured operands and the last product.
    int          m_cnt  = 0;
    logic [15:0] m_a    = 16'h0;
    logic [15:0] m_b    = 16'h0;
    logic [31:0] m_prod = 32'h0;

    crp16_alu_mul_seq #(.ALU_ADD_SEL(4'b0000), .ITER(16)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .prod_hi(prod_hi), .prod_lo(prod_lo),
        .alu_x(alu_x), .alu_y(alu_y), .alu_select(alu_select),
        .alu_result(alu_result), .alu_c(alu_c)
    );

    // Combinational ALU: the add select gives a 17-bit sum.
    assign alu_sum    = {1'b0, alu_x} + {1'b0, alu_y};
    assign alu_result = (alu_select == 4'b0000) ? alu_sum[15:0] : 16'h0000;
    assign alu_c      = (alu_select == 4'b0000) ? alu_sum[16] : 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model, advanced on each rising edge from the inputs driven at the previous falling edge.
    always @(posedge clk) begin
        if (reset) begin
            m_cnt  = 0;
            m_prod = 32'h0;
        end else if (m_cnt == 0) begin
            if (start) begin
                m_cnt = 17;
                m_a   = a;
                m_b   = b;
            end
        end else begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 1) m_prod = {16'h0, m_a} * {16'h0, m_b};
        end
    end

    // Per-cycle compare, done on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            int k;
            logic [31:0] part;
            logic [15:0] ex;
            logic [15:0] ey;
            ex = 16'h0;
            ey = 16'h0;
            if (m_cnt >= 2) begin
                k    = 17 - m_cnt;
                part = ({16'h0, m_a} * ({16'h0, m_b} & ((32'h1 << k) - 32'h1))) >> k;
                ex   = part[15:0];
                ey   = m_b[k] ? m_a : 16'h0;
            end
            chk("busy", {31'h0, busy}, {31'h0, (m_cnt > 0)});
            chk("done", {31'h0, done}, {31'h0, (m_cnt == 1)});
            chk("prod", {prod_hi, prod_lo}, m_prod);
            chk("alu_x", {16'h0, alu_x}, {16'h0, ex});
            chk("alu_y", {16'h0, alu_y}, {16'h0, ey});
            chk("alu_select", {28'h0, alu_select}, 32'h0);
        end
    end

    // Wait for done, with a bound, counting the falling edges seen.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 40);
    endtask

    task automatic mul(input logic [15:0] x, input logic [15:0] y, input logic [31:0] exp_p);
        int n;
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 16'h5A5A; b = 16'hA5A5;
        n = 1;
        if (!done) begin
            int w;
            wait_done(w);
            n += w;
        end
        chk("latency", n, 32'd17);
        chk("product", {prod_hi, prod_lo}, exp_p);
    endtask

    initial begin
        int n;
        int pulses;
        reset = 1'b1; start = 1'b0; a = 16'h0; b = 16'h0;
        repeat (2) @(negedge clk);
        chk_en = 1;
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_prod", {prod_hi, prod_lo}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        mul(16'd3, 16'd5, 32'h0000_000F);
        mul(16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
        mul(16'h8000, 16'h0002, 32'h0001_0000);
        mul(16'h1234, 16'h0000, 32'h0000_0000);

        // A start while busy, in RUN and in DONE, is ignored.
        @(negedge clk);
        a = 16'h1111; b = 16'h0202; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        chk("ignore_done_seen", {31'h0, done}, 32'h1);
        chk("ignore_product", {prod_hi, prod_lo}, 32'h0022_4422);
        a = 16'h0003; b = 16'h0003; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("ignore_no_extra_done", pulses, 32'd0);

        // Reset asserted in RUN cycle 8.
        @(negedge clk);
        a = 16'hABCD; b = 16'h1234; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset_busy", {31'h0, busy}, 32'h0);
        chk("midreset_done", {31'h0, done}, 32'h0);
        chk("midreset_prod", {prod_hi, prod_lo}, 32'h0);
        mul(16'd7, 16'd9, 32'h0000_003F);

        // Back-to-back with start held high.
        @(negedge clk);
        a = 16'h00FF; b = 16'h0101; start = 1'b1;
        wait_done(n);
        chk("b2b_first", n, 32'd17);
        chk("b2b_prod0", {prod_hi, prod_lo}, 32'h0000_FFFF);
        wait_done(n);
        chk("b2b_period1", n, 32'd18);
        chk("b2b_prod1", {prod_hi, prod_lo}, 32'h0000_FFFF);
        wait_done(n);
        chk("b2b_period2", n, 32'd18);
        chk("b2b_prod2", {prod_hi, prod_lo}, 32'h0000_FFFF);
        start = 1'b0;
        repeat (3) @(negedge clk);

        // Random start, operand and reset traffic, checked cycle by cycle.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            a     = 16'($urandom);
            b     = 16'($urandom);
            reset = ($urandom_range(0, 199) == 0);
        end
        start = 1'b0;
        reset = 1'b0;
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
